// File: rtl/filter_pkg.sv
// Shared definitions for the pixel filter engine.
//   state_e : sequencer states of the frame pass
//   mode_e  : filter selection carried on the 2-bit mode input
//   ADDR_W / DATA_W / PIX_W : frame-buffer address, data and pixel widths
package filter_pkg;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 18;
  localparam int unsigned PIX_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    HOLD,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    COPY,
    INVERT,
    THRESH,
    BRIGHT
  } mode_e;

endpackage

// File: rtl/filter_pixel_op.sv
// Combinational per-pixel filter.
// Ports:
//   mode    in  2  filter select (COPY, INVERT, THRESH, BRIGHT)
//   param   in  8  threshold level or brightness offset
//   pix_in  in  8  source pixel
//   pix_out out 8  filtered pixel
module filter_pixel_op
  import filter_pkg::*;
(
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] param,
  input  logic [PIX_W-1:0] pix_in,
  output logic [PIX_W-1:0] pix_out
);

  logic [PIX_W:0] w_sum;

  always_comb begin
    // One extra bit so the brighten carry can drive saturation.
    w_sum   = {1'b0, pix_in} + {1'b0, param};
    pix_out = pix_in;
    case (mode_e'(mode))
      COPY:    pix_out = pix_in;
      INVERT:  pix_out = ~pix_in;
      THRESH:  pix_out = (pix_in >= param) ? '1 : '0;
      BRIGHT:  pix_out = w_sum[PIX_W] ? '1 : w_sum[PIX_W-1:0];
      default: pix_out = pix_in;
    endcase
  end

endmodule

// File: rtl/pixel_filter_engine.sv
// Full-frame read/filter/write engine over a single-port frame buffer.
// Each pixel: READ (1) -> WAIT (READ_LAT) -> WRITE (1) -> HOLD (1).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle pulse, begins a pass when idle
//   abort           terminates a pass in progress (no done pulse)
//   mode, param     filter select and parameter, latched at start
//   busy            high while a pass is in progress
//   done            one-cycle pulse after the last pixel write
//   mem_addr        linear pixel address y*Width+x
//   mem_we          frame-buffer write enable
//   mem_wdata       {10'b0, pixel}
//   mem_rdata       frame-buffer read data, bits [7:0] used
module pixel_filter_engine
  import filter_pkg::*;
#(
  parameter int unsigned Width    = 640,
  parameter int unsigned Height   = 480,
  parameter int unsigned READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [7:0]        param,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned       CNT_W     = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(READ_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(Width * Height - 1);

  state_e             r_state;
  state_e             w_next;
  logic [CNT_W-1:0]   r_cnt;
  mode_e              r_mode;
  logic [PIX_W-1:0]   r_param;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_we;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_busy;
  logic               r_done;
  logic               w_last_wait;
  logic               w_last_addr;
  logic [PIX_W-1:0]   w_pix_out;
  logic               w_unused_rdata;

  // Only the pixel byte of the read word carries data.
  assign w_unused_rdata = ^mem_rdata[DATA_W-1:PIX_W];

  filter_pixel_op u_op (
    .mode    (r_mode),
    .param   (r_param),
    .pix_in  (mem_rdata[PIX_W-1:0]),
    .pix_out (w_pix_out)
  );

  always_comb begin
    w_next      = r_state;
    w_last_wait = (r_cnt == LAST_CNT);
    w_last_addr = (r_addr == LAST_ADDR);
    case (r_state)
      IDLE:    if (start && !abort) w_next = READ;
      READ:    w_next = WAIT;
      WAIT:    if (w_last_wait) w_next = WRITE;
      WRITE:   w_next = HOLD;
      HOLD:    w_next = w_last_addr ? DONE : READ;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (abort && (r_state != IDLE)) w_next = IDLE;
  end

  // Status and write-enable are registered from the next state so they line
  // up with the state they describe; an abort seen during WRITE therefore
  // still lets that write cycle complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mode  <= COPY;
      r_param <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next inside {READ, WAIT, WRITE, HOLD});
      r_done  <= (w_next == DONE);
      r_we    <= (w_next == WRITE);

      if ((r_state == IDLE) && (w_next == READ)) begin
        r_addr  <= '0;
        r_mode  <= mode_e'(mode);
        r_param <= param;
      end else if ((r_state == HOLD) && (w_next == READ)) begin
        r_addr <= r_addr + 1'b1;
      end

      if (r_state == READ) begin
        r_cnt <= '0;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // Read data is valid on the last WAIT cycle; filter it straight into
      // the write-data register, which then holds through WRITE and HOLD.
      if ((r_state == WAIT) && (w_next == WRITE)) begin
        r_wdata <= DATA_W'(w_pix_out);
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_addr  = r_addr;
  assign mem_we    = r_we;
  assign mem_wdata = r_wdata;

endmodule

// File: doc/pixel_filter_engine.md
PIXEL_FILTER_ENGINE -- requirements
Module: pixel_filter_engine

Interface
REQ-001 SHALL have parameter Width, default 640, image width in pixels.
REQ-002 SHALL have parameter Height, default 480, image height in pixels.
REQ-003 SHALL have parameter READ_LAT, default 2, cycles from address presented to mem_rdata valid.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  input  1  clock, all logic on posedge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins a full-frame pass when idle.
REQ-007 abort  input  1  terminates a pass in progress.
REQ-008 mode  input  2  filter select: 0 copy, 1 invert, 2 threshold, 3 brighten.
REQ-009 param  input  8  threshold level (mode 2) or brightness offset (mode 3).
REQ-010 busy  output  1  high while a pass is in progress.
REQ-011 done  output  1  one-cycle pulse after the last pixel write.
REQ-012 mem_addr  output  19  linear pixel address, y*Width+x, to the frame-buffer data port.
REQ-013 mem_we  output  1  frame-buffer write enable.
REQ-014 mem_wdata  output  18  write data, {10'b0, pixel[7:0]}.
REQ-015 mem_rdata  input  18  frame-buffer read data; only bits [7:0] are used.

Function
REQ-016 FSM states SHALL be IDLE, READ, WAIT, WRITE, HOLD, DONE.
REQ-017 IDLE: start=1 SHALL latch mode and param, set mem_addr=0 and busy=1, and go to READ; start while busy SHALL be ignored.
REQ-018 READ SHALL last 1 cycle with mem_we=0, then go to WAIT.
REQ-019 WAIT SHALL last READ_LAT cycles; mem_rdata[7:0] SHALL be captured on its last cycle.
REQ-020 WRITE SHALL assert mem_we=1 for exactly 1 cycle with mem_wdata = filtered pixel.
REQ-021 HOLD SHALL last 1 cycle with mem_we=0; mem_addr and mem_wdata SHALL be held stable through WRITE and HOLD.
REQ-022 Each pixel SHALL take exactly READ_LAT+3 cycles; a full 640x480 pass SHALL take 307200*5 cycles plus 1 DONE cycle.
REQ-023 After HOLD: if mem_addr = Width*Height-1, go to DONE; else increment mem_addr by 1 and go to READ.
REQ-024 DONE SHALL pulse done=1 for 1 cycle, clear busy, and return to IDLE; mem_addr SHALL retain its last value.
REQ-025 Filter: mode 0 out=p; mode 1 out=255-p; mode 2 out=(p>=param)?255:0; mode 3 out=min(p+param,255), with a 9-bit sum and saturation.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with mem_we=0 and busy=0, and done SHALL NOT pulse.
REQ-027 abort during WRITE SHALL still complete that single write cycle, because mem_we is registered.
REQ-028 Simultaneous start and abort in IDLE SHALL be treated as no start.
REQ-029 Changes to mode or param during a pass SHALL have no effect until the next start.

Reset
REQ-030 rst=1 SHALL force, on the next edge: state IDLE, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, latched mode/param=0.
REQ-031 rst SHALL take priority over start and abort; reset mid-pass SHALL abandon the pass with no done pulse.

Structure
REQ-032 A shared package filter_pkg SHALL hold the FSM state enum, the filter mode enum (COPY, INVERT, THRESH, BRIGHT) and the data width constants (ADDR_W=19, DATA_W=18, PIX_W=8).
REQ-033 The filter arithmetic SHALL be a combinational sub-module filter_pixel_op(mode, param, pix_in -> pix_out).
REQ-034 The WAIT counter SHALL be sized as $clog2(READ_LAT+1) bits; READ_LAT >= 1.

Verification
REQ-035 Width=4, Height=2, mode=1, memory model holds p=addr*10 -> 8 writes of 255-addr*10 at addrs 0..7, done at cycle 8*5+1 after start.
REQ-036 mode=2, param=128; pixels 127, 128, 200 -> writes 0, 255, 255.
REQ-037 mode=3, param=100; pixels 100, 155, 156, 255 -> writes 200, 255, 255, 255 (saturation).
REQ-038 abort asserted in the WAIT of pixel 3 -> no write to addr 3, busy=0 the next cycle, no done; a new start restarts at addr 0.
REQ-039 rst asserted mid-pass with start held high -> all outputs 0 the next cycle, IDLE; start then accepted 1 cycle after rst is released.
REQ-040 Scoreboard on every mem_we cycle: mem_addr and mem_wdata are stable across WRITE and HOLD, and mem_wdata[17:8]=0.
